// File: rtl/mem_port_arbiter_if.sv
// Shared types and the bundled fetch/data/RAM signals of the memory port arbiter.
// The slave modport is the arbiter; the master modport is everything around it.
package mem_port_arbiter_pkg;
  localparam int cXLEN = 32;
  localparam int cRegW = 5;

  typedef struct packed {
    logic             read;
    logic             write;
    logic [cXLEN-1:0] addr;
    logic [cXLEN-1:0] data;
    logic [2:0]       opType;
    logic [cRegW-1:0] rdAddr;
  } tMemOp;

  typedef struct packed {
    logic             dv;
    logic [cRegW-1:0] addr;
    logic [cXLEN-1:0] data;
  } tRegOp;

  localparam tRegOp cRegOp = '0;
endpackage

interface mem_port_arbiter_if #(
  parameter int cAddrW = 10
);
  logic                                   ifReq;
  logic [mem_port_arbiter_pkg::cXLEN-1:0] ifAddr;
  logic                                   ifGnt;
  logic [mem_port_arbiter_pkg::cXLEN-1:0] ifRdata;
  logic                                   ifRvalid;
  logic                                   flush;
  mem_port_arbiter_pkg::tMemOp            memOp;
  logic                                   memGnt;
  mem_port_arbiter_pkg::tRegOp            ldOut;
  logic                                   misalign;
  logic                                   ramEn;
  logic [3:0]                             ramWe;
  logic [cAddrW-1:0]                      ramAddr;
  logic [mem_port_arbiter_pkg::cXLEN-1:0] ramWdata;
  logic [mem_port_arbiter_pkg::cXLEN-1:0] ramRdata;

  modport slave (
    input  ifReq, ifAddr, flush, memOp, ramRdata,
    output ifGnt, ifRdata, ifRvalid, memGnt, ldOut, misalign,
           ramEn, ramWe, ramAddr, ramWdata
  );

  modport master (
    output ifReq, ifAddr, flush, memOp, ramRdata,
    input  ifGnt, ifRdata, ifRvalid, memGnt, ldOut, misalign,
           ramEn, ramWe, ramAddr, ramWdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, with
// fetch anti-starvation, byte-lane store/load handling and response tracking.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | no RAM read response due this cycle
//   FETCH_RSP | ramRdata carries the word for last cycle's fetch
//   LOAD_RSP  | ramRdata carries the word for last cycle's load
module mem_port_arbiter #(
  parameter int cXLEN      = 32,
  parameter int cRamDepth  = 1024,
  parameter int cStarveMax = 4
) (
  input  logic              clk,
  input  logic              rstN,
  mem_port_arbiter_if.slave bus
);
  localparam int cAddrW = $clog2(cRamDepth);
  localparam int cCntW  = $clog2(cStarveMax + 1);
  localparam logic [cCntW-1:0] cStarveTop = cCntW'(cStarveMax);

  typedef enum logic [1:0] {IDLE, FETCH_RSP, LOAD_RSP} tState;

  tState             state_q, state_d;
  logic [cCntW-1:0]  starve_q, starve_d;
  logic [2:0]        opType_q, opType_d;
  logic [4:0]        rdAddr_q, rdAddr_d;
  logic [1:0]        off_q, off_d;

  logic              dataReq, isStore, misal, fetchPrio;
  logic              dataGnt, fetchGnt, dataRam;
  logic [1:0]        accSize, accOff;
  logic [3:0]        laneMask;
  logic [15:0]       lane;
  mem_port_arbiter_pkg::tRegOp ld;
  logic              unused_bits;

  assign unused_bits = ^{bus.ifAddr[cXLEN-1:cAddrW+2], bus.ifAddr[1:0],
                         bus.memOp.addr[cXLEN-1:cAddrW+2]};

  // Misaligned requests are consumed without touching RAM, so fetch may share that cycle.
  always_comb begin : decode
    dataReq   = bus.memOp.read | bus.memOp.write;
    isStore   = bus.memOp.write;
    accSize   = bus.memOp.opType[1:0];
    accOff    = bus.memOp.addr[1:0];
    misal     = ((accSize == 2'b01) && accOff[0]) || (accSize[1] && (accOff != 2'b00));
    fetchPrio = bus.ifReq && !bus.flush && (starve_q == cStarveTop);
    dataGnt   = rstN && dataReq && !fetchPrio;
    fetchGnt  = rstN && bus.ifReq && !bus.flush && (!dataGnt || misal);
    dataRam   = dataGnt && !misal;
  end

  assign bus.ifGnt    = fetchGnt;
  assign bus.memGnt   = dataGnt;
  assign bus.misalign = dataGnt && misal;

  always_comb begin : ram_drive
    bus.ramEn    = 1'b0;
    bus.ramWe    = '0;
    bus.ramAddr  = '0;
    bus.ramWdata = '0;
    case (accSize)
      2'b00:   laneMask = 4'b0001;
      2'b01:   laneMask = 4'b0011;
      default: laneMask = 4'b1111;
    endcase
    if (dataRam) begin
      bus.ramEn   = 1'b1;
      bus.ramAddr = bus.memOp.addr[cAddrW+1:2];
      if (isStore) begin
        bus.ramWe = laneMask << accOff;
        case (accSize)
          2'b00:   bus.ramWdata = {4{bus.memOp.data[7:0]}};
          2'b01:   bus.ramWdata = {2{bus.memOp.data[15:0]}};
          default: bus.ramWdata = bus.memOp.data;
        endcase
      end
    end else if (fetchGnt) begin
      bus.ramEn   = 1'b1;
      bus.ramAddr = bus.ifAddr[cAddrW+1:2];
    end
  end

  always_comb begin : next_state
    state_d  = IDLE;
    starve_d = starve_q;
    opType_d = opType_q;
    rdAddr_d = rdAddr_q;
    off_d    = off_q;
    if (fetchGnt) begin
      state_d = FETCH_RSP;
    end else if (dataRam && !isStore) begin
      state_d  = LOAD_RSP;
      opType_d = bus.memOp.opType;
      rdAddr_d = bus.memOp.rdAddr;
      off_d    = accOff;
    end
    if (!bus.ifReq || fetchGnt) begin
      starve_d = '0;
    end else if (dataGnt && (starve_q != cStarveTop)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      starve_q <= '0;
      opType_q <= '0;
      rdAddr_q <= '0;
      off_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      opType_q <= opType_d;
      rdAddr_q <= rdAddr_d;
      off_q    <= off_d;
    end
  end

  // Extension source is the lane chosen by the load's own offset, not the current request's.
  always_comb begin : response
    lane = 16'(bus.ramRdata >> {off_q, 3'b000});
    ld   = mem_port_arbiter_pkg::cRegOp;
    if (state_q == LOAD_RSP) begin
      ld.dv   = (rdAddr_q != '0);
      ld.addr = rdAddr_q;
      case (opType_q[1:0])
        2'b00:   ld.data = {{24{~opType_q[2] & lane[7]}}, lane[7:0]};
        2'b01:   ld.data = {{16{~opType_q[2] & lane[15]}}, lane};
        default: ld.data = bus.ramRdata;
      endcase
    end
    bus.ldOut    = ld;
    bus.ifRvalid = (state_q == FETCH_RSP) && !bus.flush;
    bus.ifRdata  = bus.ramRdata;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: cXLEN, 32, data/address width; cRamDepth, 1024, RAM depth in 32-bit words; cStarveMax, 4, maximum consecutive data grants while fetch waits.
REQ-002 Ports SHALL be as listed (name direction width meaning):
- clk  in  1  single clock, rising edge.
- rstN  in  1  reset, asynchronous, active-low.
- ifReq  in  1  fetch read request.
- ifAddr  in  cXLEN  fetch byte address.
- ifGnt  out  1  fetch request accepted this cycle.
- ifRdata  out  cXLEN  fetched word.
- ifRvalid  out  1  ifRdata valid.
- flush  in  1  pipeline flush (branch taken).
- memOp  in  tMemOp  data request: read, write, addr, data, opType, rdAddr.
- memGnt  out  1  memOp consumed this cycle.
- ldOut  out  tRegOp  load writeback: dv, addr=rdAddr, data.
- misalign  out  1  misaligned data access pulse.
- ramEn  out  1  RAM enable.
- ramWe  out  4  RAM byte write enables.
- ramAddr  out  log2(cRamDepth)  RAM word address.
- ramWdata  out  cXLEN  RAM write data.
- ramRdata  in  cXLEN  RAM read data, one-cycle latency after ramEn.

Function
REQ-003 Word address SHALL be byteAddr[11:2]; bits above 11 SHALL be ignored (wrap), bits [1:0] SHALL select byte lanes.
REQ-004 Exactly one requester SHALL be granted per cycle; grant and RAM drive SHALL be combinational from inputs and state.
REQ-005 Data request (memOp.read or memOp.write) SHALL win over fetch, except when starveCnt equals cStarveMax and ifReq is high, in which case fetch SHALL win.
REQ-006 starveCnt SHALL increment on each data grant while ifReq is high and fetch is denied, SHALL clear on any fetch grant or when ifReq is low, and SHALL saturate at cStarveMax.
REQ-007 If read and write are both set, the request SHALL be treated as a store.
REQ-008 Store: ramWe from opType[1:0] (00 byte, 01 half, 10 word) shifted by addr[1:0]; ramWdata SHALL replicate the byte/half across lanes.
REQ-009 Load: opType 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; lane extracted by addr[1:0]; sign-extended when opType[2]=0, zero-extended otherwise.
REQ-010 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): memGnt=1, misalign=1 for one cycle, no RAM access, no ldOut; fetch MAY be granted that cycle.
REQ-011 Response tracking SHALL use states IDLE, FETCH_RSP, LOAD_RSP; a granted fetch SHALL enter FETCH_RSP, a granted aligned load SHALL enter LOAD_RSP, else IDLE; state re-evaluates every cycle (back-to-back supported).
REQ-012 In FETCH_RSP: ifRvalid=1, ifRdata=ramRdata, exactly one cycle after ifGnt.
REQ-013 In LOAD_RSP: ldOut.dv=1, ldOut.addr=latched rdAddr, ldOut.data=extended ramRdata using latched opType and addr[1:0], one cycle after memGnt.
REQ-014 Loads to rdAddr 0 SHALL still access RAM but SHALL drive ldOut.dv=0.
REQ-015 flush high SHALL block ifGnt that cycle and suppress ifRvalid of an in-flight fetch; data requests SHALL be unaffected.
REQ-016 Stores SHALL produce no response; state after a store grant SHALL be IDLE unless fetch also responds (impossible: one grant per cycle).
REQ-017 With no grant, ramEn=0, ramWe=0.

Reset
REQ-018 rstN low SHALL immediately force state IDLE, starveCnt=0, ifRvalid=0, ldOut=cRegOp, misalign=0, latched opType/rdAddr/offset=0.
REQ-019 Combinational outputs (ifGnt, memGnt, ram*) SHALL be 0 while rstN is low.
REQ-020 Reset asserted mid-response SHALL drop the pending response; no ifRvalid/ldOut.dv after release without a new grant.

Verification
REQ-021 Fetch only: ifReq=1, ifAddr=0x10, RAM word 4=0xDEADBEEF -> ifGnt, next cycle ifRvalid=1, ifRdata=0xDEADBEEF.
REQ-022 Sign/zero load: word 0x80 holds 0x000080F0; LB addr 0x201 rd=5 -> ldOut {1,5,0xFFFFFF80}; LBU same -> 0x00000080.
REQ-023 Store byte: SB addr 0x103 data 0xAB -> ramWe=4'b1000, ramWdata=0xABABABAB, ramAddr=0x40; no ldOut.
REQ-024 Starvation: ifReq and loads held high 6 cycles -> 4 data grants, 1 fetch grant, then data resumes; starveCnt cleared.
REQ-025 Misalign/flush: LW addr 0x102 -> misalign pulse, memGnt=1, ramEn=0; fetch granted then flush next cycle -> ifRvalid=0.
REQ-026 Async reset during LOAD_RSP -> ldOut.dv=0 immediately, all outputs at reset values, no stale response after release.
